exe_issuer: RTL and testbench
=============================

# exe_issuer

Issue/response controller that drives the executor from the operand-fetch side. It accepts one operation per valid/ready handshake, holds the operands stable toward the executor until the result is available, and waits for `s_exe_finished_i` on multi-cycle MDU operations, guarded by a watchdog. It then presents the result to the memory-access stage with back-pressure. It sits between the OP-stage register and the executor and replaces ad-hoc stall gluing around the MDU.

## Interface
- `MDU_TIMEOUT`, default 40: maximum EXEC cycles allowed for an MDU operation before it is aborted.
- `s_clk_i`  in  1  clock.
- `s_reset_i`  in  1  reset, synchronous and active-high.
- `s_flush_i`  in  1  discard any operation in flight.
- `s_req_valid_i`  in  1  request valid.
- `s_req_ready_o`  out  1  request accepted this cycle when valid and ready are both 1.
- `s_req_mdu_i`  in  1  operation targets the MDU (multi-cycle).
- `s_req_func_i`  in  f_part  instruction function.
- `s_req_op1_i`, `s_req_op2_i`  in  32  operands.
- `s_req_rd_i`  in  5  destination register tag.
- `s_exe_mdu_o`  out  1  drives the executor's `ICTRL_UNIT_MDU` bit.
- `s_exe_func_o`  out  f_part  function to the executor.
- `s_exe_op1_o`, `s_exe_op2_o`  out  32  operands to the executor.
- `s_exe_stall_o`, `s_exe_flush_o`  out  1  executor stall and flush.
- `s_exe_finished_i`  in  1  MDU finished.
- `s_exe_result_i`  in  32  executor result.
- `s_rsp_valid_o`  out  1  response valid.
- `s_rsp_ready_i`  in  1  consumer ready.
- `s_rsp_result_o`  out  32  captured result.
- `s_rsp_rd_o`  out  5  captured destination tag.
- `s_rsp_timeout_o`  out  1  response was produced by the watchdog.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - `s_req_ready_o` = !`s_flush_i`.
  - On accept: latch func, ops, rd and mdu into the issue registers, clear the counter, go to EXEC.
- **EXEC**
  - Issue registers drive the `s_exe_*` outputs; `s_exe_mdu_o` = latched mdu; `s_exe_stall_o` = 0.
  - ALU operation: capture `s_exe_result_i` with timeout=0 in the same cycle, go to RESP.
  - MDU operation, `s_exe_finished_i`=1: capture the result with timeout=0, go to RESP.
  - MDU operation, finished=0 and counter = `MDU_TIMEOUT`-1: capture result 0 with timeout=1, assert `s_exe_flush_o` for that cycle, go to RESP.
  - MDU operation otherwise: counter += 1.
- **RESP**
  - `s_rsp_valid_o`=1; `s_exe_mdu_o`=0; `s_exe_stall_o`=1.
  - Response outputs are stable until the handshake completes.
  - `s_req_ready_o` = `s_rsp_ready_i` & !`s_flush_i`.
  - On `s_rsp_ready_i`: if a request is accepted in the same cycle, latch it and go to EXEC; otherwise go to IDLE.
- **Flush**
  - From any state, the next state is IDLE and the counter is cleared.
  - `s_exe_flush_o` = `s_flush_i`, combinational.
  - Flush has priority over a simultaneous accept, a finish, or a timeout.
  - A response pending in RESP is dropped.
- `s_exe_*` outputs in IDLE: operands, func and mdu are 0; stall is 0.
- Counter width is $clog2(`MDU_TIMEOUT`+1). The counter saturates and never wraps.

## Timing
- **Reset:** state=IDLE; issue registers, result, rd, timeout and counter are all 0. Every output is 0 except `s_req_ready_o`=1, which follows once `s_reset_i` deasserts.
- **Reset mid-operation:** returns to IDLE with no response emitted.
- **ALU latency:** request accepted at cycle t, EXEC at t+1, `s_rsp_valid_o` at t+2.
- **MDU latency:** finished seen at EXEC cycle k gives `s_rsp_valid_o` at k+1.
- **Watchdog:** an MDU timeout gives `s_rsp_valid_o` exactly `MDU_TIMEOUT`+1 cycles after accept.
- **Throughput:** one operation per 2 cycles when back-to-back with `s_rsp_ready_i`=1.
- `s_rsp_*` outputs are registered; `s_req_ready_o` and `s_exe_flush_o` are combinational.

## Structure
- Add to p_hardisc:
  - the state enum `exe_iss_state` (EXI_IDLE, EXI_EXEC, EXI_RESP);
  - the constant `EXE_MDU_TIMEOUT` = 40, used as the parameter default.
- Single module, no sub-module. The executor is instantiated by the parent and wired through the `s_exe_*` ports.

## Test plan
- **ALU add, no back-pressure:** ops 5 and 7 accepted at t, executor model returns 12 in EXEC. Require `s_rsp_valid_o`=1 with result 12 at t+2, and `s_req_ready_o`=1 again in the same cycle.
- **MDU with back-pressure:** executor model raises finished after 33 EXEC cycles with result 0xFFFF_FFF6, and `s_rsp_ready_i` is held 0 for 3 cycles. Require result and rd to stay stable, `s_exe_stall_o`=1 during those cycles, and exactly one handshake.
- **Watchdog:** `MDU_TIMEOUT`=8 and finished is never raised. Require `s_exe_flush_o` pulsed in EXEC cycle 8, then a response with result 0 and timeout=1 at accept+9.
- **Flush mid-MDU:** `s_flush_i` at EXEC cycle 4 while a request is valid. Require state IDLE on the next cycle, no response, `s_req_ready_o`=0 during the flush cycle, and the request accepted on the following cycle.
- **Back-to-back:** a new request is valid in the same cycle as the RESP handshake. Require it to be accepted in that cycle and its response to appear 2 cycles later.
- **Reset during RESP:** `s_reset_i` held 1 for one cycle. Require every output 0 except `s_req_ready_o`=1 afterwards, and no stale response.

Source files
------------

// File: rtl/p_hardisc.sv
// Shared hardisc types and constants for the execute-stage issue controller.
package p_hardisc;

    typedef logic [3:0] f_part;

    typedef enum logic [1:0] {
        EXI_IDLE = 2'd0,
        EXI_EXEC = 2'd1,
        EXI_RESP = 2'd2
    } exe_iss_state;

    localparam int EXE_MDU_TIMEOUT = 40;

endpackage

// File: rtl/exe_issuer.sv
// Issue/response controller between the OP-stage register and the executor:
// holds operands during execution, waits on the MDU under a watchdog, and buffers the result.
module exe_issuer
    import p_hardisc::*;
#(
    parameter int MDU_TIMEOUT = EXE_MDU_TIMEOUT
) (
    input  logic        s_clk_i,
    input  logic        s_reset_i,
    input  logic        s_flush_i,
    input  logic        s_req_valid_i,
    output logic        s_req_ready_o,
    input  logic        s_req_mdu_i,
    input  f_part       s_req_func_i,
    input  logic [31:0] s_req_op1_i,
    input  logic [31:0] s_req_op2_i,
    input  logic [4:0]  s_req_rd_i,
    output logic        s_exe_mdu_o,
    output f_part       s_exe_func_o,
    output logic [31:0] s_exe_op1_o,
    output logic [31:0] s_exe_op2_o,
    output logic        s_exe_stall_o,
    output logic        s_exe_flush_o,
    input  logic        s_exe_finished_i,
    input  logic [31:0] s_exe_result_i,
    output logic        s_rsp_valid_o,
    input  logic        s_rsp_ready_i,
    output logic [31:0] s_rsp_result_o,
    output logic [4:0]  s_rsp_rd_o,
    output logic        s_rsp_timeout_o
);

    localparam int CNT_W = $clog2(MDU_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_TIMEOUT - 1);

    exe_iss_state     r_state;
    logic             r_mdu;
    f_part            r_func;
    logic [31:0]      r_op1;
    logic [31:0]      r_op2;
    logic [4:0]       r_rd;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_result;
    logic [4:0]       r_rsp_rd;
    logic             r_timeout;

    logic w_exec;
    logic w_busy;
    logic w_accept;
    logic w_done;
    logic w_timeout;

    assign w_exec    = (r_state == EXI_EXEC);
    assign w_busy    = (r_state != EXI_IDLE);
    assign w_accept  = s_req_valid_i & s_req_ready_o;
    assign w_done    = w_exec & (~r_mdu | s_exe_finished_i);
    // A finish in the last allowed cycle still wins over the watchdog.
    assign w_timeout = w_exec & r_mdu & ~s_exe_finished_i & (r_cnt == CNT_LAST);

    assign s_req_ready_o = ~s_reset_i & ~s_flush_i &
                           ((r_state == EXI_IDLE) | ((r_state == EXI_RESP) & s_rsp_ready_i));

    assign s_exe_mdu_o   = w_exec & r_mdu;
    assign s_exe_func_o  = w_busy ? r_func : '0;
    assign s_exe_op1_o   = w_busy ? r_op1 : '0;
    assign s_exe_op2_o   = w_busy ? r_op2 : '0;
    assign s_exe_stall_o = (r_state == EXI_RESP);
    assign s_exe_flush_o = s_flush_i | w_timeout;

    assign s_rsp_valid_o   = (r_state == EXI_RESP);
    assign s_rsp_result_o  = r_result;
    assign s_rsp_rd_o      = r_rsp_rd;
    assign s_rsp_timeout_o = r_timeout;

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            r_state   <= EXI_IDLE;
            r_mdu     <= 1'b0;
            r_func    <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_rd      <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_rsp_rd  <= '0;
            r_timeout <= 1'b0;
        end else if (s_flush_i) begin
            r_state <= EXI_IDLE;
            r_cnt   <= '0;
        end else if (w_accept) begin
            // Accept is only possible in IDLE or on a RESP handshake, so this covers both.
            r_state <= EXI_EXEC;
            r_mdu   <= s_req_mdu_i;
            r_func  <= s_req_func_i;
            r_op1   <= s_req_op1_i;
            r_op2   <= s_req_op2_i;
            r_rd    <= s_req_rd_i;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                EXI_EXEC: begin
                    if (w_done) begin
                        r_result  <= s_exe_result_i;
                        r_rsp_rd  <= r_rd;
                        r_timeout <= 1'b0;
                        r_state   <= EXI_RESP;
                    end else if (w_timeout) begin
                        r_result  <= '0;
                        r_rsp_rd  <= r_rd;
                        r_timeout <= 1'b1;
                        r_state   <= EXI_RESP;
                    end else if (r_cnt != {CNT_W{1'b1}}) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                EXI_RESP: begin
                    if (s_rsp_ready_i) begin
                        r_state <= EXI_IDLE;
                    end
                end
                default: begin
                    r_state <= EXI_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exe_issuer.sv
// Bench for exe_issuer: directed scenarios followed by random traffic checked
// against a transaction-level scoreboard and a simple executor model.
module tb_exe_issuer;
    import p_hardisc::*;

    localparam int WD_TIMEOUT   = 8;
    localparam int MAIN_TIMEOUT = EXE_MDU_TIMEOUT;
    localparam int N_RANDOM     = 80;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        timeout;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqMdu = 1'b0;
    f_part       reqFunc = '0;
    logic [31:0] reqOp1 = '0;
    logic [31:0] reqOp2 = '0;
    logic [4:0]  reqRd = '0;
    logic        rspReady = 1'b0;

    logic        reqReady, exeMdu, exeStall, exeFlush, exeFinished;
    f_part       exeFunc;
    logic [31:0] exeOp1, exeOp2, exeResult;
    logic        rspValid, rspTimeout;
    logic [31:0] rspResult;
    logic [4:0]  rspRd;

    logic        wdReqReady, wdExeMdu, wdExeStall, wdExeFlush;
    f_part       wdExeFunc;
    logic [31:0] wdExeOp1, wdExeOp2;
    logic        wdRspValid, wdRspTimeout;
    logic [31:0] wdRspResult;
    logic [4:0]  wdRspRd;
    logic [31:0] wdExeResult = 32'hDEAD_BEEF;

    int   checks = 0;
    int   errors = 0;
    int   exeCnt = 0;
    int   mduDelay = 0;
    bit   scoreOn = 1'b0;
    rsp_t scoreQ[$];

    always #5 clk = ~clk;

    exe_issuer dut (
        .s_clk_i(clk), .s_reset_i(reset), .s_flush_i(flush),
        .s_req_valid_i(reqValid), .s_req_ready_o(reqReady), .s_req_mdu_i(reqMdu),
        .s_req_func_i(reqFunc), .s_req_op1_i(reqOp1), .s_req_op2_i(reqOp2), .s_req_rd_i(reqRd),
        .s_exe_mdu_o(exeMdu), .s_exe_func_o(exeFunc), .s_exe_op1_o(exeOp1), .s_exe_op2_o(exeOp2),
        .s_exe_stall_o(exeStall), .s_exe_flush_o(exeFlush),
        .s_exe_finished_i(exeFinished), .s_exe_result_i(exeResult),
        .s_rsp_valid_o(rspValid), .s_rsp_ready_i(rspReady), .s_rsp_result_o(rspResult),
        .s_rsp_rd_o(rspRd), .s_rsp_timeout_o(rspTimeout)
    );

    exe_issuer #(.MDU_TIMEOUT(WD_TIMEOUT)) dutWd (
        .s_clk_i(clk), .s_reset_i(reset), .s_flush_i(flush),
        .s_req_valid_i(reqValid), .s_req_ready_o(wdReqReady), .s_req_mdu_i(reqMdu),
        .s_req_func_i(reqFunc), .s_req_op1_i(reqOp1), .s_req_op2_i(reqOp2), .s_req_rd_i(reqRd),
        .s_exe_mdu_o(wdExeMdu), .s_exe_func_o(wdExeFunc), .s_exe_op1_o(wdExeOp1), .s_exe_op2_o(wdExeOp2),
        .s_exe_stall_o(wdExeStall), .s_exe_flush_o(wdExeFlush),
        .s_exe_finished_i(1'b0), .s_exe_result_i(wdExeResult),
        .s_rsp_valid_o(wdRspValid), .s_rsp_ready_i(rspReady), .s_rsp_result_o(wdRspResult),
        .s_rsp_rd_o(wdRspRd), .s_rsp_timeout_o(wdRspTimeout)
    );

    // Reference executor: what the functional units compute for a given function code.
    function automatic logic [31:0] refResult(input f_part func, input logic [31:0] a, input logic [31:0] b);
        case (func)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a ^ b;
            4'd3:    return a & b;
            4'd4:    return a * b;
            default: return a | b;
        endcase
    endfunction

    assign exeResult = refResult(exeFunc, exeOp1, exeOp2);

    // The MDU model raises finished on the mduDelay-th consecutive cycle it is driven.
    always @(posedge clk) begin
        if (reset || !exeMdu) exeCnt <= 0;
        else                  exeCnt <= exeCnt + 1;
    end
    assign exeFinished = exeMdu && (mduDelay != 0) && (exeCnt == mduDelay - 1);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic mdu, input f_part func,
                                 input logic [31:0] op1, input logic [31:0] op2, input logic [4:0] rd);
        reqValid = valid;
        reqMdu   = mdu;
        reqFunc  = func;
        reqOp1   = op1;
        reqOp2   = op2;
        reqRd    = rd;
    endtask

    task automatic applyReset();
        reset    = 1'b1;
        flush    = 1'b0;
        rspReady = 1'b0;
        mduDelay = 0;
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        stepCycle();
        stepCycle();
        reset = 1'b0;
        #1;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "Ctl"}, 32'({exeMdu, exeFunc, exeStall, exeFlush, rspValid, rspTimeout, rspRd}), 32'd0);
        checkOutput({tag, "Data"}, exeOp1 | exeOp2 | rspResult, 32'd0);
        checkOutput({tag, "Ready"}, 32'(reqReady), 32'd1);
    endtask

    // Scoreboard monitor for the random phase: every handshake must match the oldest accepted request.
    always @(posedge clk) begin
        if (scoreOn && rspValid && rspReady) begin
            checkOutput("rndSpurious", 32'(scoreQ.size() != 0), 32'd1);
            if (scoreQ.size() != 0) begin
                rsp_t exp;
                exp = scoreQ.pop_front();
                checkOutput("rndResult", rspResult, exp.result);
                checkOutput("rndRd", 32'(rspRd), 32'(exp.rd));
                checkOutput("rndTimeout", 32'(rspTimeout), 32'(exp.timeout));
            end
        end
    end

    initial begin
        int  n;
        bit  haveReq;
        bit  willAccept;
        int  sent;
        int  pDelay;
        rsp_t pExp;

        // Reset state
        applyReset();
        checkIdleOutputs("reset");

        // ALU add without back-pressure
        rspReady = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'd0, 32'd5, 32'd7, 5'd3);
        #1;
        checkOutput("aluAccept", 32'(reqReady), 32'd1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        #1;
        checkOutput("aluExecOps", {exeOp1[15:0], exeOp2[15:0]}, {16'd5, 16'd7});
        checkOutput("aluExecCtl", 32'({exeStall, rspValid, reqReady, exeMdu}), 32'd0);
        stepCycle();
        checkOutput("aluRspValid", 32'(rspValid), 32'd1);
        checkOutput("aluRspResult", rspResult, 32'd12);
        checkOutput("aluRspRd", 32'({rspTimeout, rspRd}), 32'd3);
        checkOutput("aluReadyAgain", 32'(reqReady), 32'd1);
        stepCycle();
        checkOutput("aluRspDone", 32'(rspValid), 32'd0);

        // MDU with back-pressure: finished on EXEC cycle 33
        mduDelay = 33;
        rspReady = 1'b0;
        applyStimulus(1'b1, 1'b1, 4'd4, 32'hFFFF_FFFE, 32'd5, 5'd9);
        stepCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        #1;
        checkOutput("mduExecCtl", 32'({exeMdu, exeStall}), 32'b10);
        n = 1;
        while (!rspValid && n < 60) begin
            stepCycle();
            n++;
        end
        checkOutput("mduLatency", n, 34);
        for (int i = 0; i < 3; i++) begin
            checkOutput("mduHoldCtl", 32'({rspValid, exeStall, exeMdu, rspTimeout}), 32'b1100);
            checkOutput("mduHoldResult", rspResult, 32'hFFFF_FFF6);
            checkOutput("mduHoldRd", 32'(rspRd), 32'd9);
            stepCycle();
        end
        rspReady = 1'b1;
        #1;
        checkOutput("mduReleaseReady", 32'(reqReady), 32'd1);
        stepCycle();
        checkOutput("mduOneHandshake", 32'(rspValid), 32'd0);

        // Watchdog on the MDU_TIMEOUT=8 instance
        applyReset();
        rspReady = 1'b1;
        applyStimulus(1'b1, 1'b1, 4'd4, 32'd3, 32'd4, 5'd17);
        stepCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        #1;
        for (int k = 1; k <= WD_TIMEOUT; k++) begin
            checkOutput($sformatf("wdExec%0d", k), 32'({wdExeFlush, wdRspValid}), 32'({(k == WD_TIMEOUT), 1'b0}));
            stepCycle();
        end
        checkOutput("wdRspValid", 32'(wdRspValid), 32'd1);
        checkOutput("wdRspResult", wdRspResult, 32'd0);
        checkOutput("wdRspTag", 32'({wdRspTimeout, wdRspRd}), 32'({1'b1, 5'd17}));
        stepCycle();
        checkOutput("wdRspDone", 32'(wdRspValid), 32'd0);

        // Flush in the fourth EXEC cycle of an MDU op with a request pending
        applyReset();
        rspReady = 1'b1;
        applyStimulus(1'b1, 1'b1, 4'd4, 32'd6, 32'd6, 5'd5);
        stepCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        stepCycle();
        stepCycle();
        stepCycle();
        flush = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'd0, 32'd100, 32'd23, 5'd7);
        #1;
        checkOutput("flushReady", 32'(reqReady), 32'd0);
        checkOutput("flushExeFlush", 32'(exeFlush), 32'd1);
        stepCycle();
        flush = 1'b0;
        #1;
        checkOutput("flushIdle", 32'({rspValid, exeMdu, exeStall}), 32'd0);
        checkOutput("flushIdleOps", exeOp1 | exeOp2, 32'd0);
        checkOutput("flushRetryReady", 32'(reqReady), 32'd1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        stepCycle();
        checkOutput("flushRetryRsp", {rspResult[23:0], 3'b0, rspRd}, {24'd123, 3'b0, 5'd7});
        checkOutput("flushRetryValid", 32'(rspValid), 32'd1);
        stepCycle();

        // Back-to-back: second request accepted on the RESP handshake
        applyStimulus(1'b1, 1'b0, 4'd1, 32'd50, 32'd8, 5'd1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 4'd2, 32'hF0, 32'h0F, 5'd2);
        #1;
        checkOutput("b2bFirstRsp", 32'({rspValid, reqReady}), 32'b11);
        checkOutput("b2bFirstResult", rspResult, 32'd42);
        stepCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, '0);
        #1;
        checkOutput("b2bSecondExec", 32'({rspValid, exeStall}), 32'd0);
        checkOutput("b2bSecondOp", exeOp1, 32'hF0);
        stepCycle();
        checkOutput("b2bSecondRsp", {rspResult[15:0], 11'd0, rspRd}, {16'hFF, 11'd0, 5'd2});
        checkOutput("b2bSecondValid", 32'(rspValid), 32'd1);

        // Reset while a response is pending
        rspReady = 1'b0;
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        #1;
        checkIdleOutputs("rstResp");
        stepCycle();
        checkOutput("rstNoStale", 32'(rspValid), 32'd0);

        // Random traffic against the scoreboard
        applyReset();
        scoreOn    = 1'b1;
        haveReq    = 1'b0;
        willAccept = 1'b0;
        sent       = 0;
        pDelay     = 0;
        pExp       = '{32'd0, 5'd0, 1'b0};
        for (int c = 0; c < 8000; c++) begin
            if (willAccept) begin
                scoreQ.push_back(pExp);
                mduDelay = reqMdu ? pDelay : 0;
                haveReq  = 1'b0;
                sent++;
            end
            if (sent == N_RANDOM) break;
            if (!haveReq && $urandom_range(0, 3) != 0) begin
                int r;
                haveReq = 1'b1;
                applyStimulus(1'b1, 1'($urandom_range(0, 1)), f_part'($urandom_range(0, 5)),
                              $urandom(), $urandom(), 5'($urandom_range(0, 31)));
                r = $urandom_range(0, 9);
                if (r == 0)      pDelay = 0;
                else if (r == 1) pDelay = MAIN_TIMEOUT;
                else if (r == 2) pDelay = MAIN_TIMEOUT + 1;
                else             pDelay = $urandom_range(1, 12);
                pExp.timeout = reqMdu && (pDelay == 0 || pDelay > MAIN_TIMEOUT);
                pExp.result  = pExp.timeout ? 32'd0 : refResult(reqFunc, reqOp1, reqOp2);
                pExp.rd      = reqRd;
            end
            reqValid = haveReq;
            rspReady = ($urandom_range(0, 9) < 7);
            #1;
            willAccept = reqValid && reqReady;
            stepCycle();
        end
        reqValid = 1'b0;
        rspReady = 1'b1;
        checkOutput("rndSent", sent, N_RANDOM);
        for (int i = 0; i < 100 && scoreQ.size() != 0; i++) stepCycle();
        stepCycle();
        checkOutput("rndDrained", scoreQ.size(), 0);
        scoreOn = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
